// File: rtl/mcu_system_top.sv
// UART1 -> 4-entry FIFO -> UART0 bridge with RS-485 driver enable and status word.
// Define SPI_MIRROR_EN to also mirror every forwarded byte onto the SPI master (SS0).
//   RX state | meaning
//   IDLE     | waiting for a falling edge on synced RXD1
//   START    | half-bit wait, re-check start bit
//   DATA     | sampling 8 data bits LSB first at mid-bit
//   STOP     | sampling stop bit, push or flag framing error
module mcu_system_top #(
    parameter int BIT_CYCLES = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        RXD1,
    output logic        RTS1,
    output logic        TXD1,
    output logic        TXD1_EN,
    input  logic        CTS1,
    output logic        TXD0,
    output logic        TXD0_EN,
    input  logic        CTS0,
    input  logic        RXD0,
    output logic        RTS0,
    input  logic        EXTIN,
    output logic        MOSI,
    output logic        SCK,
    input  logic        MISO,
    output logic        SS0,
    output logic        SS1,
    output logic        SS2,
    output logic        SS3,
    output logic [15:0] SYSTEM_OUT
);
    localparam int TW = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0] FULL_BIT = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic unused_inputs;
    assign unused_inputs = ^{CTS1, RXD0, MISO};

    assign TXD1    = 1'b1;
    assign TXD1_EN = 1'b0;
    assign RTS0    = 1'b0;
    assign SS1     = 1'b1;
    assign SS2     = 1'b1;
    assign SS3     = 1'b1;

    logic rxd_meta, rxd_sync, rxd_prev;
    logic cts_meta, cts_sync, ext_meta, ext_sync;

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
        end else begin
            rxd_meta <= RXD1;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            cts_meta <= CTS0;
            cts_sync <= cts_meta;
            ext_meta <= EXTIN;
            ext_sync <= ext_meta;
        end
    end

    rx_state_t       rx_state;
    logic [TW-1:0]   rx_timer;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shreg;
    logic            ferr;
    logic            rx_push;

    assign rx_push = (rx_state == RX_STOP) && (rx_timer == '0) && rxd_sync;

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            ferr     <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_timer <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (rx_timer == '0) begin
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                        rx_timer <= FULL_BIT;
                        rx_bit   <= '0;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer == '0) begin
                        rx_shreg <= {rxd_sync, rx_shreg[7:1]};
                        rx_timer <= FULL_BIT;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                default: begin
                    if (rx_timer == '0) begin
                        rx_state <= RX_IDLE;
                        if (!rxd_sync) ferr <= 1'b1;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
            endcase
        end
    end

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;
    logic [7:0] last_byte;
    logic       ovf;
    logic       fifo_full, push_ok, pop, tx_idle, spi_idle;

    assign fifo_full = (fifo_count == 3'd4);
    assign push_ok   = rx_push && !fifo_full;
    assign pop       = (fifo_count != 3'd0) && cts_sync && ext_sync && tx_idle && spi_idle;

    always_ff @(posedge HCLK) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_shreg;
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_byte  <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (rx_push) last_byte <= rx_shreg;
            if (rx_push && fifo_full) ovf <= 1'b1;
        end
    end

    // The stop-bit's last cycle counts as idle so back-to-back frames stay exactly 10 bits.
    logic          tx_busy, txd0_q, txd0_en_q;
    logic [TW-1:0] tx_timer;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shreg;

    assign tx_idle = !tx_busy || ((tx_timer == '0) && (tx_bit == 4'd9));

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            tx_busy   <= 1'b0;
            txd0_q    <= 1'b1;
            txd0_en_q <= 1'b0;
            tx_timer  <= '0;
            tx_bit    <= '0;
            tx_shreg  <= '0;
        end else if (pop) begin
            tx_busy   <= 1'b1;
            txd0_q    <= 1'b0;
            txd0_en_q <= 1'b1;
            tx_timer  <= FULL_BIT;
            tx_bit    <= '0;
            tx_shreg  <= {1'b1, fifo_mem[rd_ptr]};
        end else if (tx_busy) begin
            if (tx_timer == '0) begin
                if (tx_bit == 4'd9) begin
                    tx_busy   <= 1'b0;
                    txd0_q    <= 1'b1;
                    txd0_en_q <= 1'b0;
                end else begin
                    txd0_q   <= tx_shreg[0];
                    tx_shreg <= {1'b1, tx_shreg[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                    tx_timer <= FULL_BIT;
                end
            end else begin
                tx_timer <= tx_timer - 1'b1;
            end
        end
    end

    assign TXD0    = txd0_q;
    assign TXD0_EN = txd0_en_q;

`ifdef SPI_MIRROR_EN
    // spi_cnt counts cycles since SS0 fell: SCK high on cnt[1], MOSI shifts on each fall.
    logic       spi_busy, spi_sck, spi_mosi, spi_ss;
    logic [5:0] spi_cnt, spi_cnt_nxt;
    logic [7:0] spi_shreg;

    assign spi_cnt_nxt = spi_cnt + 6'd1;
    assign spi_idle    = !spi_busy;

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            spi_busy  <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_ss    <= 1'b1;
            spi_cnt   <= '0;
            spi_shreg <= '0;
        end else if (pop) begin
            spi_busy  <= 1'b1;
            spi_ss    <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= fifo_mem[rd_ptr][7];
            spi_shreg <= {fifo_mem[rd_ptr][6:0], 1'b0};
            spi_cnt   <= '0;
        end else if (spi_busy) begin
            spi_cnt <= spi_cnt_nxt;
            spi_sck <= (spi_cnt_nxt < 6'd32) && spi_cnt_nxt[1];
            if ((spi_cnt_nxt[1:0] == 2'b00) && (spi_cnt_nxt < 6'd32)) begin
                spi_mosi  <= spi_shreg[7];
                spi_shreg <= {spi_shreg[6:0], 1'b0};
            end
            if (spi_cnt_nxt == 6'd34) begin
                spi_busy <= 1'b0;
                spi_ss   <= 1'b1;
                spi_mosi <= 1'b0;
            end
        end
    end

    assign SCK  = spi_sck;
    assign MOSI = spi_mosi;
    assign SS0  = spi_ss;
`else
    assign spi_idle = 1'b1;
    assign SCK      = 1'b0;
    assign MOSI     = 1'b0;
    assign SS0      = 1'b1;
`endif

    logic        rts1_q;
    logic [15:0] sys_q;

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            rts1_q <= 1'b0;
            sys_q  <= '0;
        end else begin
            rts1_q <= (fifo_count < 3'd4);
            sys_q  <= {last_byte, ovf, ferr, 1'b0, fifo_count, tx_busy, ext_sync};
        end
    end

    assign RTS1       = rts1_q;
    assign SYSTEM_OUT = sys_q;

endmodule

// File: tb/tb_mcu_system_top.sv
// Directed bench for mcu_system_top: reset, single byte, burst/overflow, framing error, pause, SPI mirror.
module tb_mcu_system_top;
    localparam int B = 64;

    logic        HCLK = 1'b0;
    logic        HRESETn, RXD1, CTS1, CTS0, RXD0, EXTIN, MISO;
    logic        RTS1, TXD1, TXD1_EN, TXD0, TXD0_EN, RTS0, MOSI, SCK, SS0, SS1, SS2, SS3;
    logic [15:0] SYSTEM_OUT;

    int n_checks = 0;
    int n_errors = 0;

    mcu_system_top #(.BIT_CYCLES(B)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .RXD1(RXD1), .RTS1(RTS1), .TXD1(TXD1),
        .TXD1_EN(TXD1_EN), .CTS1(CTS1), .TXD0(TXD0), .TXD0_EN(TXD0_EN), .CTS0(CTS0),
        .RXD0(RXD0), .RTS0(RTS0), .EXTIN(EXTIN), .MOSI(MOSI), .SCK(SCK), .MISO(MISO),
        .SS0(SS0), .SS1(SS1), .SS2(SS2), .SS3(SS3), .SYSTEM_OUT(SYSTEM_OUT)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge for driving/sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        RXD1 = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RXD1 = d[i];
            tick(B);
        end
        RXD1 = stop_bit;
        tick(B);
        RXD1 = 1'b1;
    endtask

    task automatic capture_tx(input int max_wait, output logic [7:0] data, output int en_cnt,
                              output int waited, output logic start_ok, output logic stop_ok);
        data = '0; en_cnt = 0; waited = 0; start_ok = 1'b0; stop_ok = 1'b0;
        do begin
            tick(1);
            waited++;
        end while (TXD0 !== 1'b0 && waited <= max_wait);
        if (waited > max_wait) return;
        for (int k = 0; k < 10 * B; k++) begin
            if (k > 0) tick(1);
            if (TXD0_EN === 1'b1) en_cnt++;
            if (k % B == B / 2) begin
                if (k / B == 0)      start_ok = (TXD0 === 1'b0);
                else if (k / B == 9) stop_ok  = (TXD0 === 1'b1);
                else                 data[k / B - 1] = TXD0;
            end
        end
    endtask

    task automatic watch_en(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (TXD0_EN !== 1'b0) seen++;
        end
    endtask

    task automatic spi_capture(input int max_wait, output logic [7:0] bits, output int pulses,
                               output int low_cycles);
        int   waited;
        logic prev;
        bits = '0; pulses = 0; low_cycles = 0; waited = 0;
        do begin
            tick(1);
            waited++;
        end while (SS0 !== 1'b0 && waited <= max_wait);
        if (waited > max_wait) return;
        low_cycles = 1;
        prev = SCK;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (SS0 !== 1'b0) break;
            low_cycles++;
            if (SCK === 1'b1 && prev === 1'b0) begin
                bits = {bits[6:0], MOSI};
                pulses++;
            end
            prev = SCK;
        end
    endtask

    task automatic spi_quiet(input int cycles, output int bad);
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (SCK !== 1'b0 || MOSI !== 1'b0 || SS0 !== 1'b1) bad++;
        end
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] data;
        logic [7:0] exp_bytes [4];
        int         en_cnt, waited, seen, pulses, low_cycles;
        logic       start_ok, stop_ok;

        exp_bytes[0] = 8'hFF; exp_bytes[1] = 8'hAA; exp_bytes[2] = 8'hBB; exp_bytes[3] = 8'hCC;
        HRESETn = 1'b1; RXD1 = 1'b1; CTS1 = 1'b0; CTS0 = 1'b0; RXD0 = 1'b1; EXTIN = 1'b0; MISO = 1'b0;

        // Reset
        tick(5);
        check_val("rst_txd0", TXD0, 1'b1);
        check_val("rst_txd0_en", TXD0_EN, 1'b0);
        check_val("rst_rts1", RTS1, 1'b0);
        check_val("rst_sys", SYSTEM_OUT, 16'h0000);
        check_val("rst_spi", {SCK, MOSI, SS0}, 3'b001);
        check_val("const_outs", {TXD1, TXD1_EN, RTS0, SS1, SS2, SS3}, 6'b100111);
        HRESETn = 1'b0;
        tick(1);
        check_val("rts1_after_rel", RTS1, 1'b1);
        check_val("sys_after_rel", SYSTEM_OUT, 16'h0000);
        CTS0 = 1'b1; EXTIN = 1'b1;
        tick(4);
        check_val("sys_extin", SYSTEM_OUT, 16'h0001);

        // Single byte
        fork
            send_frame(8'hA5, 1'b1);
            capture_tx(12 * B, data, en_cnt, waited, start_ok, stop_ok);
        join
        check_val("a5_found", waited <= 12 * B, 1'b1);
        check_val("a5_data", data, 8'hA5);
        check_val("a5_start_stop", {start_ok, stop_ok}, 2'b11);
        check_val("a5_en_cycles", en_cnt, 640);
        tick(1);
        check_val("a5_idle_after", {TXD0, TXD0_EN}, 2'b10);
        tick(3);
        check_val("a5_sys", SYSTEM_OUT, 16'hA501);

        // Burst with stall, then overflow
        CTS0 = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) send_frame(exp_bytes[i], 1'b1);
        tick(4);
        check_val("burst_sys_full", SYSTEM_OUT, 16'hCC11);
        check_val("burst_rts1", RTS1, 1'b0);
        send_frame(8'h00, 1'b1);
        tick(4);
        check_val("ovf_sys", SYSTEM_OUT, 16'h0091);
        check_val("ovf_no_tx", TXD0_EN, 1'b0);
        CTS0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            capture_tx(16, data, en_cnt, waited, start_ok, stop_ok);
            check_val($sformatf("burst_data%0d", i), data, exp_bytes[i]);
            check_val($sformatf("burst_frame%0d", i), {start_ok, stop_ok, en_cnt == 640}, 3'b111);
            if (i > 0) check_val($sformatf("burst_b2b%0d", i), waited, 1);
        end
        tick(4);
        check_val("burst_sys_end", SYSTEM_OUT, 16'h0081);
        check_val("burst_rts1_end", RTS1, 1'b1);

        // Framing error
        fork
            send_frame(8'h3C, 1'b0);
            watch_en(12 * B, seen);
        join
        check_val("ferr_no_tx", seen, 0);
        check_val("ferr_sys", SYSTEM_OUT, 16'h00C1);

        // Pause
        EXTIN = 1'b0;
        tick(4);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            watch_en(20 * B + 8, seen);
        join
        check_val("pause_no_tx", seen, 0);
        check_val("pause_sys", SYSTEM_OUT, 16'h22C8);
        EXTIN = 1'b1;
        capture_tx(16, data, en_cnt, waited, start_ok, stop_ok);
        check_val("pause_data0", data, 8'h11);
        capture_tx(16, data, en_cnt, waited, start_ok, stop_ok);
        check_val("pause_data1", data, 8'h22);
        check_val("pause_b2b", waited, 1);
        tick(4);
        check_val("pause_sys_end", SYSTEM_OUT, 16'h22C1);

        // SPI mirror (or SPI pins idle when not built in)
        fork
            send_frame(8'h96, 1'b1);
            capture_tx(12 * B, data, en_cnt, waited, start_ok, stop_ok);
`ifdef SPI_MIRROR_EN
            spi_capture(12 * B, data, pulses, low_cycles);
`else
            spi_quiet(20 * B, seen);
`endif
        join
`ifdef SPI_MIRROR_EN
        check_val("spi_bits", data, 8'h96);
        check_val("spi_pulses", pulses, 8);
        check_val("spi_ss_low", low_cycles, 34);
`else
        check_val("spi_quiet", seen, 0);
        check_val("spi_uart_data", data, 8'h96);
`endif
        check_val("spi_uart_en", en_cnt, 640);
        tick(4);
        check_val("spi_sys", SYSTEM_OUT, 16'h96C1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
